// File: rtl/counter_min_hr.sv
`default_nettype none
// ============================================================================
// Module   : counter_min_hr
// Brief    : BCD minute/hour timekeeper advanced by seconds-counter wrap,
//            with time-set mode and optional 12-hour AM/PM display.
// Revision : 1.0 - initial release
// ============================================================================
module counter_min_hr #(
    parameter int HOUR_24 = 1
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic [7:0] sec_count_in,
    input  logic       set_mode_in,
    input  logic       inc_min_in,
    input  logic       inc_hr_in,
    output logic [7:0] min_out,
    output logic [7:0] hr_out,
    output logic       pm_out,
    output logic       hr_tick_out,
    output logic       day_wrap_out
);

    localparam logic [7:0] C_HR_RESET = (HOUR_24 != 0) ? 8'h00 : 8'h12;
    localparam logic [7:0] C_HR_LAST  = (HOUR_24 != 0) ? 8'h23 : 8'h12;
    localparam logic [7:0] C_HR_FIRST = (HOUR_24 != 0) ? 8'h00 : 8'h01;

    logic [7:0] r_prev_sec;
    logic       w_wrap;
    logic [7:0] w_min_nxt;
    logic       w_min_roll;
    logic [7:0] w_hr_nxt;
    logic       w_pm_flip;
    logic       w_day_end;

    function automatic logic [7:0] f_bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Only the exact 59 -> 00 transition counts; glitches and non-BCD values are ignored.
    assign w_wrap     = (r_prev_sec == 8'h59) && (sec_count_in == 8'h00);
    assign w_min_roll = (min_out == 8'h59);
    assign w_min_nxt  = w_min_roll ? 8'h00 : f_bcd_inc(min_out);
    assign w_hr_nxt   = (hr_out == C_HR_LAST) ? C_HR_FIRST : f_bcd_inc(hr_out);
    assign w_pm_flip  = (HOUR_24 == 0) && (hr_out == 8'h11);
    assign w_day_end  = (HOUR_24 != 0) ? (hr_out == 8'h23) : ((hr_out == 8'h11) && pm_out);

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_prev_sec   <= 8'h00;
            min_out      <= 8'h00;
            hr_out       <= C_HR_RESET;
            pm_out       <= 1'b0;
            hr_tick_out  <= 1'b0;
            day_wrap_out <= 1'b0;
        end else begin
            r_prev_sec   <= sec_count_in;
            hr_tick_out  <= 1'b0;
            day_wrap_out <= 1'b0;
            if (set_mode_in) begin
                // Manual set: minutes wrap without carrying, and wraps are dropped.
                if (inc_min_in)
                    min_out <= w_min_nxt;
                if (inc_hr_in) begin
                    hr_out <= w_hr_nxt;
                    if (w_pm_flip)
                        pm_out <= ~pm_out;
                end
            end else if (w_wrap) begin
                min_out <= w_min_nxt;
                if (w_min_roll) begin
                    hr_out       <= w_hr_nxt;
                    hr_tick_out  <= 1'b1;
                    day_wrap_out <= w_day_end;
                    if (w_pm_flip)
                        pm_out <= ~pm_out;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_min_hr.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_min_hr
// Brief    : Self-checking bench driving 24-hour and 12-hour instances in
//            lockstep against a time-of-day reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_min_hr;

    logic       clk_in;
    logic       reset_in;
    logic [7:0] sec_count_in;
    logic       set_mode_in;
    logic       inc_min_in;
    logic       inc_hr_in;

    logic [7:0] min24, hr24, min12, hr12;
    logic       pm24, tick24, dw24, pm12, tick12, dw12;

    int n_checks;
    int n_pass;

    // Reference: time of day as plain integers, hour 0..23 for both displays.
    int         m_min;
    int         m_hr;
    logic [7:0] m_prev;
    logic       m_tick;
    logic       m_dw;

    counter_min_hr #(.HOUR_24(1)) dut24 (
        .clk_in(clk_in), .reset_in(reset_in), .sec_count_in(sec_count_in),
        .set_mode_in(set_mode_in), .inc_min_in(inc_min_in), .inc_hr_in(inc_hr_in),
        .min_out(min24), .hr_out(hr24), .pm_out(pm24),
        .hr_tick_out(tick24), .day_wrap_out(dw24)
    );

    counter_min_hr #(.HOUR_24(0)) dut12 (
        .clk_in(clk_in), .reset_in(reset_in), .sec_count_in(sec_count_in),
        .set_mode_in(set_mode_in), .inc_min_in(inc_min_in), .inc_hr_in(inc_hr_in),
        .min_out(min12), .hr_out(hr12), .pm_out(pm12),
        .hr_tick_out(tick12), .day_wrap_out(dw12)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [37:0] obs();
        return {min24, hr24, pm24, tick24, dw24, min12, hr12, pm12, tick12, dw12};
    endfunction

    function automatic logic [37:0] expv();
        int h12;
        h12 = (m_hr % 12 == 0) ? 12 : (m_hr % 12);
        return {bcd(m_min), bcd(m_hr), 1'b0, m_tick, m_dw,
                bcd(m_min), bcd(h12), (m_hr >= 12), m_tick, m_dw};
    endfunction

    task automatic model_reset();
        m_min  = 0;
        m_hr   = 0;
        m_prev = 8'h00;
        m_tick = 1'b0;
        m_dw   = 1'b0;
    endtask

    // One clock: drive on the falling edge, advance the model at the rising edge.
    task automatic step(input logic [7:0] sec, input logic set,
                        input logic im, input logic ih);
        @(negedge clk_in);
        sec_count_in = sec;
        set_mode_in  = set;
        inc_min_in   = im;
        inc_hr_in    = ih;
        @(posedge clk_in);
        m_tick = 1'b0;
        m_dw   = 1'b0;
        if (set) begin
            if (im) m_min = (m_min + 1) % 60;
            if (ih) m_hr  = (m_hr + 1) % 24;
        end else if (m_prev == 8'h59 && sec == 8'h00) begin
            m_min = m_min + 1;
            if (m_min == 60) begin
                m_min  = 0;
                m_hr   = (m_hr + 1) % 24;
                m_tick = 1'b1;
                m_dw   = (m_hr == 0);
            end
        end
        m_prev = sec;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset_in     = 1'b1;
        sec_count_in = 8'h00;
        set_mode_in  = 1'b0;
        inc_min_in   = 1'b0;
        inc_hr_in    = 1'b0;
        model_reset();
        @(negedge clk_in);
        reset_in = 1'b0;
    endtask

    task automatic set_time(input int th, input int tm);
        for (int i = 0; i < 24 && m_hr != th; i++) begin
            step(8'h30, 1'b1, 1'b0, 1'b1);
            n_checks++;
            if (obs() !== expv()) $display("FAIL set_hr: got %h want %h", obs(), expv());
            else n_pass++;
        end
        for (int i = 0; i < 60 && m_min != tm; i++) begin
            step(8'h30, 1'b1, 1'b1, 1'b0);
            n_checks++;
            if (obs() !== expv()) $display("FAIL set_min: got %h want %h", obs(), expv());
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (obs() !== expv()) $display("FAIL reset_state: got %h want %h", obs(), expv());
        else n_pass++;
        n_checks++;
        if ({min24, hr24, hr12, pm12} !== {8'h00, 8'h00, 8'h12, 1'b0})
            $display("FAIL reset_const: got %h %h %h %b want 00 00 12 0", min24, hr24, hr12, pm12);
        else n_pass++;
    endtask

    task automatic test_minute_wrap();
        logic [7:0] seq [3];
        seq = '{8'h58, 8'h59, 8'h00};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(seq[i], 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs() !== expv()) $display("FAIL min_wrap step%0d: got %h want %h", i, obs(), expv());
            else n_pass++;
        end
        n_checks++;
        if ({min24, hr24, tick24} !== {8'h01, 8'h00, 1'b0})
            $display("FAIL min_wrap_const: got %h %h %b want 01 00 0", min24, hr24, tick24);
        else n_pass++;
    endtask

    task automatic test_day_wrap();
        do_reset();
        set_time(23, 59);
        step(8'h59, 1'b0, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({hr24, min24, tick24, dw24, hr12, pm12, dw12} !==
            {8'h00, 8'h00, 1'b1, 1'b1, 8'h12, 1'b0, 1'b1})
            $display("FAIL day_wrap: got %h %h %b %b %h %b %b want 00 00 1 1 12 0 1",
                     hr24, min24, tick24, dw24, hr12, pm12, dw12);
        else n_pass++;
        step(8'h01, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({tick24, dw24, tick12, dw12} !== 4'b0000)
            $display("FAIL day_wrap_pulse_len: got %b%b%b%b want 0000", tick24, dw24, tick12, dw12);
        else n_pass++;
    endtask

    task automatic test_noon();
        do_reset();
        set_time(11, 59);
        step(8'h59, 1'b0, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({hr12, min12, pm12, tick12, dw12} !== {8'h12, 8'h00, 1'b1, 1'b1, 1'b0})
            $display("FAIL noon: got %h %h %b %b %b want 12 00 1 1 0", hr12, min12, pm12, tick12, dw12);
        else n_pass++;
        n_checks++;
        if (obs() !== expv()) $display("FAIL noon_model: got %h want %h", obs(), expv());
        else n_pass++;
    endtask

    task automatic test_set_mode();
        do_reset();
        set_time(5, 10);
        step(8'h59, 1'b1, 1'b0, 1'b0);
        step(8'h00, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({hr24, min24, tick24} !== {8'h05, 8'h10, 1'b0})
            $display("FAIL set_discard_wrap: got %h %h %b want 05 10 0", hr24, min24, tick24);
        else n_pass++;
        step(8'h30, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if ({hr24, min24, hr12, min12} !== {8'h06, 8'h11, 8'h06, 8'h11})
            $display("FAIL set_both: got %h %h %h %h want 06 11 06 11", hr24, min24, hr12, min12);
        else n_pass++;
        set_time(6, 59);
        step(8'h30, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if ({hr24, min24, tick24, dw24} !== {8'h06, 8'h00, 1'b0, 1'b0})
            $display("FAIL set_min_nocarry: got %h %h %b %b want 06 00 0 0", hr24, min24, tick24, dw24);
        else n_pass++;
        step(8'h30, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if ({hr24, min24} !== {8'h06, 8'h00})
            $display("FAIL inc_ignored: got %h %h want 06 00", hr24, min24);
        else n_pass++;
    endtask

    task automatic test_non_bcd();
        logic [7:0] seq [5];
        seq = '{8'h59, 8'h45, 8'h00, 8'h5A, 8'h00};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(seq[i], 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs() !== expv()) $display("FAIL non_bcd step%0d: got %h want %h", i, obs(), expv());
            else n_pass++;
        end
        n_checks++;
        if (min24 !== 8'h00) $display("FAIL non_bcd_const: got %h want 00", min24);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        set_time(14, 37);
        step(8'h59, 1'b0, 1'b0, 1'b0);
        #2;
        reset_in = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({min24, hr24, tick24, dw24, hr12, pm12} !== {8'h00, 8'h00, 2'b00, 8'h12, 1'b0})
            $display("FAIL async_reset: got %h %h %b %b %h %b want 00 00 0 0 12 0",
                     min24, hr24, tick24, dw24, hr12, pm12);
        else n_pass++;
        @(negedge clk_in);
        sec_count_in = 8'h00;
        reset_in     = 1'b0;
        step(8'h00, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({min24, hr24} !== {8'h00, 8'h00})
            $display("FAIL post_reset_no_wrap: got %h %h want 00 00", min24, hr24);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] sec;
        logic       set;
        int         r;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 9));
            sec = (r < 4) ? 8'h59 : (r < 8) ? 8'h00 : 8'($urandom);
            set = ($urandom_range(0, 9) == 0);
            step(sec, set, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
            n_checks++;
            if (obs() !== expv()) $display("FAIL random cyc%0d: got %h want %h", i, obs(), expv());
            else n_pass++;
        end
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        reset_in     = 1'b1;
        sec_count_in = 8'h00;
        set_mode_in  = 1'b0;
        inc_min_in   = 1'b0;
        inc_hr_in    = 1'b0;
        model_reset();
        test_reset();
        test_minute_wrap();
        test_day_wrap();
        test_noon();
        test_set_mode();
        test_non_bcd();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
